lenet_mac_accum: RTL and testbench

- Downstream stage of the LeNet conv datapath's signed 12x6 -> 19-bit multiplier.
- Consumes one product per cycle, accumulates KERNEL_LEN products per output pixel, adds a per-map bias, then applies arithmetic right-shift requantisation, optional ReLU and saturation.
- Emits a 12-bit signed activation in the same format the multiplier takes on its 12-bit operand, so it feeds the next layer directly.
- Marks the last pixel of each feature map.

---
 rtl/lenet_mac_accum_if.sv | 27 ++
 rtl/lenet_mac_accum.sv | 114 +++++++++++
 tb/tb_lenet_mac_accum.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_mac_accum_if.sv
// Stream bundle for lenet_mac_accum: multiplier product beats in, requantised activations out.
// The master side drives products, bias and act_ready; the slave side is the accumulator stage.
interface lenet_mac_accum_if #(
   parameter int PROD_W = 19,
   parameter int BIAS_W = 12,
   parameter int OUT_W  = 12
) ();
   logic signed [PROD_W-1:0] prod_data;
   logic                     prod_valid;
   logic                     prod_ready;
   logic signed [BIAS_W-1:0] bias_data;
   logic signed [OUT_W-1:0]  act_data;
   logic                     act_valid;
   logic                     act_ready;
   logic                     act_last;
   logic                     busy;

   modport master (
      output prod_data, prod_valid, bias_data, act_ready,
      input  prod_ready, act_data, act_valid, act_last, busy
   );

   modport slave (
      input  prod_data, prod_valid, bias_data, act_ready,
      output prod_ready, act_data, act_valid, act_last, busy
   );
endinterface

// File: rtl/lenet_mac_accum.sv
// LeNet conv MAC tail: accumulates KERNEL_LEN products plus a scaled bias per pixel, then
// floors by OUT_SHIFT, applies optional ReLU and saturates to an OUT_W activation.
module lenet_mac_accum #(
   parameter int PROD_W      = 19,
   parameter int BIAS_W      = 12,
   parameter int ACC_W       = 24,
   parameter int OUT_W       = 12,
   parameter int KERNEL_LEN  = 25,
   parameter int OUT_PER_MAP = 576,
   parameter int BIAS_SHIFT  = 4,
   parameter int OUT_SHIFT   = 6,
   parameter int RELU_EN     = 1
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   lenet_mac_accum_if.slave s
);
   localparam int BEAT_W = (KERNEL_LEN  > 1) ? $clog2(KERNEL_LEN)  : 1;
   localparam int PIX_W  = (OUT_PER_MAP > 1) ? $clog2(OUT_PER_MAP) : 1;

   localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(KERNEL_LEN - 1);
   localparam logic [PIX_W-1:0]        PIX_LAST  = PIX_W'(OUT_PER_MAP - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ~SAT_MAX;

   logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic [PIX_W-1:0]        pix_cnt_q,  pix_cnt_d;
   logic signed [ACC_W-1:0] acc_q,      acc_d;
   logic signed [OUT_W-1:0] act_data_q, act_data_d;
   logic                    act_valid_q, act_valid_d;
   logic                    act_last_q,  act_last_d;

   logic                    out_free;
   logic                    closing;
   logic                    prod_rdy;
   logic                    beat_fire;
   logic                    load;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shifted;
   logic signed [ACC_W-1:0] clamped;

   always_comb begin
      out_free  = !act_valid_q || s.act_ready;
      closing   = (beat_cnt_q == BEAT_LAST);
      // Only the closing beat needs a free output register; earlier beats never stall.
      prod_rdy  = !(closing && !out_free);
      beat_fire = s.prod_valid && prod_rdy;
      load      = beat_fire && closing;

      prod_ext = {{(ACC_W - PROD_W){s.prod_data[PROD_W-1]}}, s.prod_data};
      bias_ext = {{(ACC_W - BIAS_W){s.bias_data[BIAS_W-1]}}, s.bias_data} <<< BIAS_SHIFT;
      sum      = ((beat_cnt_q == '0) ? bias_ext : acc_q) + prod_ext;

      shifted = sum >>> OUT_SHIFT;
      clamped = shifted;
      if ((RELU_EN != 0) && shifted[ACC_W-1]) begin
         clamped = '0;
      end
      if (clamped > SAT_MAX) begin
         clamped = SAT_MAX;
      end else if (clamped < SAT_MIN) begin
         clamped = SAT_MIN;
      end

      beat_cnt_d  = beat_cnt_q;
      acc_d       = acc_q;
      pix_cnt_d   = pix_cnt_q;
      act_data_d  = act_data_q;
      act_valid_d = act_valid_q;
      act_last_d  = act_last_q;

      if (beat_fire) begin
         acc_d      = sum;
         beat_cnt_d = closing ? '0 : beat_cnt_q + 1'b1;
      end

      // A reload in the same cycle as an unload keeps act_valid high with no bubble.
      if (load) begin
         act_data_d  = clamped[OUT_W-1:0];
         act_valid_d = 1'b1;
         act_last_d  = (pix_cnt_q == PIX_LAST);
         pix_cnt_d   = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
      end else if (s.act_ready) begin
         act_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         beat_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         acc_q       <= '0;
         act_data_q  <= '0;
         act_valid_q <= 1'b0;
         act_last_q  <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         acc_q       <= acc_d;
         act_data_q  <= act_data_d;
         act_valid_q <= act_valid_d;
         act_last_q  <= act_last_d;
      end
   end

   assign s.prod_ready = prod_rdy;
   assign s.act_data   = act_data_q;
   assign s.act_valid  = act_valid_q;
   assign s.act_last   = act_last_q;
   assign s.busy       = (beat_cnt_q != '0);
endmodule

// File: tb/tb_lenet_mac_accum.sv
// Bench for lenet_mac_accum: three instances (defaults, ReLU off, 4-pixel maps) share one
// stimulus stream and are compared each cycle against an integer-arithmetic window model.
module tb_lenet_mac_accum;
   localparam int KL = 25;

   logic ap_clk = 1'b0;
   logic ap_rst_n;
   always #5 ap_clk = ~ap_clk;

   lenet_mac_accum_if ifa ();
   lenet_mac_accum_if ifb ();
   lenet_mac_accum_if ifc ();

   lenet_mac_accum u_dut_a (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s(ifa.slave));
   lenet_mac_accum #(.RELU_EN(0)) u_dut_b (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s(ifb.slave));
   lenet_mac_accum #(.OUT_PER_MAP(4)) u_dut_c (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .s(ifc.slave));

   int errors = 0;
   int checks = 0;

   // Reference model: window progress, expected output register per instance.
   int          win_cnt;
   int          win_sum;
   bit          exp_valid;
   int          exp_data [3];
   bit          exp_last [3];
   int          pix [3];
   int          relu_cfg [3] = '{1, 0, 1};
   int          opm_cfg [3]  = '{576, 576, 4};
   int          c_out_idx;
   logic [15:0] c_last_mask;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
         $error("check %s did not match", tag);
      end
   endtask

   function automatic int requant(input int sum_v, input bit relu);
      int q;
      q = sum_v / 64;
      if (sum_v < 0 && q * 64 != sum_v) q = q - 1;
      if (relu && q < 0) q = 0;
      if (q > 2047) q = 2047;
      if (q < -2048) q = -2048;
      return q;
   endfunction

   function automatic logic signed [31:0] obs_data(input int i);
      logic signed [31:0] v;
      case (i)
         0:       v = ifa.act_data;
         1:       v = ifb.act_data;
         default: v = ifc.act_data;
      endcase
      return v;
   endfunction

   // Packs {prod_ready, act_valid, act_last, busy} of instance i.
   function automatic logic [3:0] obs_flags(input int i);
      logic [3:0] v;
      case (i)
         0:       v = {ifa.prod_ready, ifa.act_valid, ifa.act_last, ifa.busy};
         1:       v = {ifb.prod_ready, ifb.act_valid, ifb.act_last, ifb.busy};
         default: v = {ifc.prod_ready, ifc.act_valid, ifc.act_last, ifc.busy};
      endcase
      return v;
   endfunction

   task automatic drive(input logic v, input int d, input int b, input logic r);
      ifa.prod_valid = v; ifa.prod_data = 19'(d); ifa.bias_data = 12'(b); ifa.act_ready = r;
      ifb.prod_valid = v; ifb.prod_data = 19'(d); ifb.bias_data = 12'(b); ifb.act_ready = r;
      ifc.prod_valid = v; ifc.prod_data = 19'(d); ifc.bias_data = 12'(b); ifc.act_ready = r;
   endtask

   task automatic compare_outputs();
      logic [3:0] f;
      for (int i = 0; i < 3; i++) begin
         f = obs_flags(i);
         check($sformatf("act_valid_%0d", i), 32'(f[2]), 32'(exp_valid));
         check($sformatf("busy_%0d", i), 32'(f[0]), 32'(win_cnt != 0));
         if (exp_valid) begin
            check($sformatf("act_data_%0d", i), obs_data(i), exp_data[i]);
            check($sformatf("act_last_%0d", i), 32'(f[1]), 32'(exp_last[i]));
         end
      end
   endtask

   task automatic cycle(input logic v, input int d, input int b, input logic r, output bit fired);
      bit exp_ready;
      bit closed;
      bit unload;
      drive(v, d, b, r);
      #1;
      exp_ready = !(win_cnt == KL - 1 && exp_valid && !r);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("prod_ready_%0d", i), 32'(obs_flags(i)[3]), 32'(exp_ready));
      end
      fired  = v && exp_ready;
      unload = exp_valid && r;
      if (unload) begin
         if (ifc.act_last === 1'b1 && c_out_idx < 16) c_last_mask[c_out_idx] = 1'b1;
         c_out_idx++;
      end
      @(posedge ap_clk);
      #1;
      closed = 1'b0;
      if (fired) begin
         win_sum = (win_cnt == 0) ? b * 16 + d : win_sum + d;
         if (win_cnt == KL - 1) begin
            closed  = 1'b1;
            win_cnt = 0;
            for (int i = 0; i < 3; i++) begin
               exp_data[i] = requant(win_sum, relu_cfg[i] != 0);
               exp_last[i] = (pix[i] == opm_cfg[i] - 1);
               pix[i]      = (pix[i] + 1) % opm_cfg[i];
            end
         end else begin
            win_cnt++;
         end
      end
      if (closed) exp_valid = 1'b1;
      else if (unload) exp_valid = 1'b0;
      compare_outputs();
   endtask

   task automatic do_reset();
      logic [3:0] f;
      ap_rst_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0);
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1;
      ap_rst_n  = 1'b1;
      win_cnt   = 0;
      win_sum   = 0;
      exp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_data[i] = 0;
         exp_last[i] = 1'b0;
         pix[i]      = 0;
         f = obs_flags(i);
         check($sformatf("rst_act_valid_%0d", i), 32'(f[2]), 0);
         check($sformatf("rst_act_data_%0d", i), obs_data(i), 0);
         check($sformatf("rst_act_last_%0d", i), 32'(f[1]), 0);
         check($sformatf("rst_busy_%0d", i), 32'(f[0]), 0);
      end
   endtask

   // Streams one full window; rand_mag=0 selects the constant d_fixed for every beat.
   task automatic window(input int b_first, input int d_fixed, input int rand_mag,
                         input bit bias_wobble, input int ready_pct, input int idle_pct);
      int beats = 0;
      int budget = 0;
      int d, b;
      bit f, v, r;
      while (beats < KL) begin
         if (budget > 300) begin
            check("window_budget", beats, KL);
            return;
         end
         budget++;
         d = (rand_mag == 0) ? d_fixed : int'($urandom_range(0, 2 * rand_mag)) - rand_mag;
         b = (beats == 0 || !bias_wobble) ? b_first : int'($urandom_range(0, 4095)) - 2048;
         v = (int'($urandom_range(0, 99)) >= idle_pct);
         r = (int'($urandom_range(0, 99)) < ready_pct);
         cycle(v, d, b, r, f);
         if (f) beats++;
      end
   endtask

   task automatic drain();
      bit f;
      for (int k = 0; k < 3; k++) cycle(1'b0, 0, 0, 1'b1, f);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      bit f;
      ap_rst_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0);
      c_out_idx   = 0;
      c_last_mask = '0;
      do_reset();

      // Basic window: 25 x 64, bias 0 -> 1600 >>> 6 = 25, visible the cycle after the last beat.
      window(0, 64, 0, 1'b0, 100, 0);
      check("basic_valid", 32'(ifa.act_valid), 1);
      check("basic_data", obs_data(0), 25);

      // Bias 4 (64 after alignment); later bias_data changes must be ignored.
      window(4, 64, 0, 1'b1, 100, 0);
      check("bias_data", obs_data(0), 26);

      window(0, -64, 0, 1'b0, 100, 0);
      check("neg_relu", obs_data(0), 0);
      check("neg_norelu", obs_data(1), -25);

      window(0, -65, 0, 1'b0, 100, 0);
      check("floor_norelu", obs_data(1), -26);

      window(0, 262143, 0, 1'b0, 100, 0);
      check("sat_pos", obs_data(0), 2047);
      window(0, -262144, 0, 1'b0, 100, 0);
      check("sat_neg", obs_data(1), -2048);
      drain();

      // Backpressure: hold the first output, stream the second window into the stall.
      window(-4, 64, 0, 1'b0, 0, 0);
      for (int k = 0; k < KL - 1; k++) begin
         cycle(1'b1, 128, 0, 1'b0, f);
         check("bp_accept", 32'(f), 1);
      end
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 128, 0, 1'b0, f);
         check("bp_stall_ready", 32'(ifa.prod_ready), 0);
         check("bp_held_data", obs_data(0), 24);
      end
      cycle(1'b1, 128, 0, 1'b1, f);
      check("bp_reload_valid", 32'(ifa.act_valid), 1);
      check("bp_reload_data", obs_data(0), 50);
      drain();

      // Map boundary on the 4-pixel instance: last on outputs 4 and 8 only.
      do_reset();
      c_out_idx   = 0;
      c_last_mask = '0;
      for (int w = 0; w < 9; w++) window(int'($urandom_range(0, 255)) - 128, 0, 3000, 1'b0, 70, 20);
      drain();
      check("map_outputs", c_out_idx, 9);
      check("map_last_mask", 32'(c_last_mask), 32'h0088);

      // Reset in the middle of a window discards the partial sum.
      for (int k = 0; k < 10; k++) cycle(1'b1, 5000, 7, 1'b1, f);
      check("pre_rst_busy", 32'(ifa.busy), 1);
      do_reset();
      window(2, 100, 0, 1'b0, 100, 0);
      check("post_rst_data_a", obs_data(0), 39);
      check("post_rst_data_b", obs_data(1), 39);
      drain();

      // Randomised windows with random gaps and backpressure.
      for (int w = 0; w < 30; w++) begin
         window(int'($urandom_range(0, 4095)) - 2048, 0,
                (w % 3 == 0) ? 262143 : 4000, w[0], 60, 20);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
